gxsim_hostreg_initiator: RTL and testbench

//  Initiator side of the simulated GenX host-register bus. Consumes a framed

---
 rtl/gxsim_hostreg_initiator_pkg.sv | 32 +++
 rtl/gxsim_word_shifter.sv | 37 +++
 rtl/gxsim_hostreg_initiator.sv | 143 ++++++++++++++
 tb/tb_gxsim_hostreg_initiator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gxsim_hostreg_initiator_pkg.sv
// Shared constants for the GenX host-register initiator: opcodes, frame sizes,
// FSM state encoding and the shifter control bundle.
package gxsim_hostreg_initiator_pkg;

    localparam logic [7:0] OP_WRITE_DEF    = 8'h02;
    localparam logic [7:0] OP_READ_DEF     = 8'h0B;
    localparam int         DUMMY_BYTES_DEF = 0;
    localparam int         WORD_BYTES      = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_WDATA   = 3'd2;
    localparam logic [2:0] ST_WSTROBE = 3'd3;
    localparam logic [2:0] ST_DUMMY   = 3'd4;
    localparam logic [2:0] ST_RSAMPLE = 3'd5;
    localparam logic [2:0] ST_RSEND   = 3'd6;
    localparam logic [2:0] ST_DRAIN   = 3'd7;

    typedef struct packed {
        logic       clear;
        logic       load;
        logic       shift;
        logic [7:0] byte_in;
    } shift_ctrl_t;

    // States in which the initiator can take an rx byte.
    function automatic logic rx_state(input logic [2:0] s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_WDATA) ||
               (s == ST_DUMMY) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/gxsim_word_shifter.sv
// 32-bit byte shifter with a word-position counter; shifts MSB first in both
// directions, so the same register collects rx words and emits tx words.
module gxsim_word_shifter
    import gxsim_hostreg_initiator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  shift_ctrl_t ctrl,
    input  logic [31:0] load_word,
    output logic [31:0] shifted,
    output logic [7:0]  top_byte,
    output logic        done
);

    logic [31:0] word;
    logic [1:0]  count;

    assign shifted  = {word[23:0], ctrl.byte_in};
    assign top_byte = word[31:24];
    assign done     = ctrl.shift && (count == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word  <= '0;
            count <= '0;
        end else if (ctrl.load) begin
            word  <= load_word;
            count <= '0;
        end else if (ctrl.shift) begin
            word  <= shifted;
            count <= count + 2'd1;
        end else if (ctrl.clear) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/gxsim_hostreg_initiator.sv
// Host-register bus initiator: decodes framed QSPI bytes into register
// writes/reads. Define GXSIM_HOSTREG_BURST_EN for auto-incrementing bursts.
//
// state    | meaning
// IDLE     | waiting for opcode byte
// ADDR     | collecting 4 address bytes
// WDATA    | collecting 4 write-data bytes
// WSTROBE  | write_strobe high for this cycle
// DUMMY    | discarding turnaround bytes before read data
// RSAMPLE  | capturing rdata for the current address
// RSEND    | streaming 4 read bytes
// DRAIN    | discarding bytes until chip select drops
module gxsim_hostreg_initiator
    import gxsim_hostreg_initiator_pkg::*;
#(
    parameter logic [7:0] OP_WRITE    = OP_WRITE_DEF,
    parameter logic [7:0] OP_READ     = OP_READ_DEF,
    parameter int         DUMMY_BYTES = DUMMY_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_active,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] address,
    output logic [31:0] wdata,
    output logic        write_strobe,
    input  logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] err_count
);

`ifdef GXSIM_HOSTREG_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        is_read;
    logic [7:0]  dummy_left;
    logic        rx_fire;
    logic        tx_fire;
    logic        op_legal;
    shift_ctrl_t sh_ctrl;
    logic [31:0] sh_shifted;
    logic        sh_done;

    assign rx_fire  = cs_active && rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign op_legal = (rx_data == OP_WRITE) || (rx_data == OP_READ);

    always_comb begin
        sh_ctrl.clear   = (state == ST_IDLE);
        sh_ctrl.load    = (state == ST_RSAMPLE) && cs_active;
        sh_ctrl.shift   = (rx_fire && ((state == ST_ADDR) || (state == ST_WDATA))) ||
                          ((state == ST_RSEND) && tx_fire);
        sh_ctrl.byte_in = (state == ST_RSEND) ? 8'h00 : rx_data;
    end

    gxsim_word_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (sh_ctrl),
        .load_word (rdata),
        .shifted   (sh_shifted),
        .top_byte  (tx_data),
        .done      (sh_done)
    );

    // Dropping chip select abandons the frame from any state.
    always_comb begin
        state_next = state;
        if (!cs_active) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (rx_fire) state_next = op_legal ? ST_ADDR : ST_DRAIN;
                ST_ADDR:    if (sh_done) begin
                                if (!is_read)
                                    state_next = ST_WDATA;
                                else if (DUMMY_BYTES == 0)
                                    state_next = ST_RSAMPLE;
                                else
                                    state_next = ST_DUMMY;
                            end
                ST_WDATA:   if (sh_done) state_next = ST_WSTROBE;
                ST_WSTROBE: state_next = BURST ? ST_WDATA : ST_DRAIN;
                ST_DUMMY:   if (rx_fire && (dummy_left == 8'd0)) state_next = ST_RSAMPLE;
                ST_RSAMPLE: state_next = ST_RSEND;
                ST_RSEND:   if (sh_done) state_next = BURST ? ST_RSAMPLE : ST_DRAIN;
                ST_DRAIN:   state_next = ST_DRAIN;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            is_read      <= 1'b0;
            dummy_left   <= '0;
            address      <= '0;
            wdata        <= '0;
            write_strobe <= 1'b0;
            tx_valid     <= 1'b0;
            rx_ready     <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_next;
            rx_ready     <= rx_state(state_next);
            tx_valid     <= (state_next == ST_RSEND);
            // Registered so a strobe already earned survives cs falling.
            write_strobe <= (state == ST_WDATA) && sh_done;

            if ((state == ST_IDLE) && rx_fire) begin
                is_read <= (rx_data == OP_READ);
                if (!op_legal && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end

            if ((state == ST_ADDR) && sh_done) begin
                address    <= sh_shifted;
                dummy_left <= 8'(DUMMY_BYTES - 1);
            end

            if ((state == ST_WDATA) && sh_done)
                wdata <= sh_shifted;

            if ((state == ST_DUMMY) && rx_fire && (dummy_left != 8'd0))
                dummy_left <= dummy_left - 8'd1;

            if (BURST && cs_active &&
                ((state == ST_WSTROBE) || ((state == ST_RSEND) && sh_done)))
                address <= address + 32'd4;
        end
    end

endmodule

// File: tb/tb_gxsim_hostreg_initiator.sv
// Self-checking bench for gxsim_hostreg_initiator: table-driven frames plus
// hand sequences for stall, abort, reset and burst wrap.
module tb_gxsim_hostreg_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_active;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        write_strobe;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] wq[$];
    logic [7:0]  tq[$];
    logic [63:0] w_exp;
    logic [7:0]  t_exp;

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h4) ? 32'h1234_5678 : ~a;
    endfunction

    assign rdata = rdata_of(address);

    gxsim_hostreg_initiator dut (
        .clk          (clk),
        .reset        (reset),
        .cs_active    (cs_active),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .address      (address),
        .wdata        (wdata),
        .write_strobe (write_strobe),
        .rdata        (rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .err_count    (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: strobes and accepted tx bytes are matched against queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (write_strobe) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_strobe: got addr %h wdata %h want no strobe", address, wdata);
                end else begin
                    w_exp = wq.pop_front();
                    check("strobe_addr", address, w_exp[63:32]);
                    check("strobe_wdata", wdata, w_exp[31:0]);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_tx: got %h want no tx byte", tx_data);
                end else begin
                    t_exp = tq.pop_front();
                    check("tx_byte", {24'h0, tx_data}, {24'h0, t_exp});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL rx_timeout: byte %h not accepted, want accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8]);
    endtask

    task automatic push_tx(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tq.push_back(w[31 - 8*i -: 8]);
    endtask

    task automatic wait_drained(input string name);
        for (int k = 0; k < 200 && (wq.size() != 0 || tq.size() != 0); k++) tick();
        if (wq.size() != 0 || tq.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d strobes %0d bytes pending want 0", name, wq.size(), tq.size());
            wq.delete();
            tq.delete();
        end
    endtask

    task automatic start_frame;
        cs_active = 1'b1;
        tick();
    endtask

    task automatic end_frame;
        cs_active = 1'b0;
        repeat (3) tick();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          write;
        bit          read;
        logic [31:0] exp_tx;
        logic [15:0] exp_err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{8'h02, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         16'd0, 32'h0000_0008, 32'hDEAD_BEEF};
        vt[1] = '{8'h0B, 32'h0000_0004, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 16'd0, 32'h0000_0004, 32'hDEAD_BEEF};
        vt[2] = '{8'h55, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0, 32'h0,         16'd1, 32'h0000_0004, 32'hDEAD_BEEF};
        vt[3] = '{8'h02, 32'h0000_0100, 32'h0102_0304, 1'b1, 1'b0, 32'h0,         16'd1, 32'h0000_0100, 32'h0102_0304};
        vt[4] = '{8'h0B, 32'h0000_0020, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFDF, 16'd1, 32'h0000_0020, 32'h0102_0304};
        vt[5] = '{8'hFF, 32'hAAAA_AAAA, 32'h0B0B_0B0B, 1'b0, 1'b0, 32'h0,         16'd2, 32'h0000_0020, 32'h0102_0304};

        reset = 1'b1; cs_active = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        tick(); tick();
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_err", {16'h0, err_count}, 32'h0);
        reset = 1'b0;
        tick();
        check("idle_rx_ready", {31'h0, rx_ready}, 32'h1);

        for (int i = 0; i < 6; i++) begin
            start_frame();
            if (vt[i].write) wq.push_back({vt[i].exp_addr, vt[i].exp_wdata});
            if (vt[i].read) push_tx(vt[i].exp_tx);
            send_byte(vt[i].op);
            send_word(vt[i].addr);
            if (!vt[i].read) send_word(vt[i].data);
            wait_drained("vec");
            tick();
            check("vec_tx_idle", {31'h0, tx_valid}, 32'h0);
            end_frame();
            check("vec_err", {16'h0, err_count}, {16'h0, vt[i].exp_err});
            check("vec_addr", address, vt[i].exp_addr);
            check("vec_wdata", wdata, vt[i].exp_wdata);
        end

        // Read latency and a 3-cycle tx stall in the middle of the word.
        start_frame();
        tx_ready = 1'b0;
        push_tx(32'h1234_5678);
        send_byte(8'h0B);
        send_word(32'h0000_0004);
        @(negedge clk);
        check("rd_lat_early", {31'h0, tx_valid}, 32'h0);
        @(negedge clk);
        check("rd_lat_valid", {31'h0, tx_valid}, 32'h1);
        check("rd_first_byte", {24'h0, tx_data}, 32'h12);
        tick();
        tx_ready = 1'b1;
        tick(); tick();
        tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_data", {24'h0, tx_data}, 32'h56);
            check("stall_valid", {31'h0, tx_valid}, 32'h1);
        end
        tick();
        tx_ready = 1'b1;
        wait_drained("stall");
        @(negedge clk);
        check("rd_done_valid", {31'h0, tx_valid}, 32'h0);
        end_frame();

        // Abort a write partway through the data word.
        start_frame();
        send_byte(8'h02);
        send_word(32'h0000_0000);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cs_active = 1'b0;
        repeat (3) tick();
        check("abort_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("abort_wdata", wdata, 32'h0102_0304);
        check("abort_addr", address, 32'h0);

        // Full write with cs dropping right after the last byte still strobes.
        start_frame();
        wq.push_back({32'h0000_0040, 32'hCAFE_F00D});
        send_byte(8'h02);
        send_word(32'h0000_0040);
        send_word(32'hCAFE_F00D);
        cs_active = 1'b0;
        @(negedge clk);
        check("late_cs_strobe", {31'h0, write_strobe}, 32'h1);
        wait_drained("late_cs");
        end_frame();

        // Reset in the middle of a read clears every output immediately.
        start_frame();
        tx_ready = 1'b0;
        send_byte(8'h0B);
        send_word(32'h0000_0004);
        tick(); tick();
        check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("mid_rst_addr", address, 32'h0);
        check("mid_rst_wdata", wdata, 32'h0);
        check("mid_rst_err", {16'h0, err_count}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("mid_rst_strobe", {31'h0, write_strobe}, 32'h0);
        cs_active = 1'b0;
        tx_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        start_frame();
        wq.push_back({32'h0000_000C, 32'h0000_0001});
        send_byte(8'h02);
        send_word(32'h0000_000C);
        send_word(32'h0000_0001);
        wait_drained("post_rst");
        end_frame();
        check("post_rst_addr", address, 32'h0000_000C);

        // Write at the top of the address space with two data words.
        start_frame();
        wq.push_back({32'hFFFF_FFFC, 32'h1122_3344});
`ifdef GXSIM_HOSTREG_BURST_EN
        wq.push_back({32'h0000_0000, 32'h5566_7788});
`endif
        send_byte(8'h02);
        send_word(32'hFFFF_FFFC);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        wait_drained("burst");
        end_frame();
        repeat (3) tick();
`ifdef GXSIM_HOSTREG_BURST_EN
        check("burst_addr", address, 32'h0000_0004);
        check("burst_wdata", wdata, 32'h5566_7788);
`else
        check("burst_addr", address, 32'hFFFF_FFFC);
        check("burst_wdata", wdata, 32'h1122_3344);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
